// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - mode encoding and initial-pattern helper for led_sequencer
//
// Purpose: shared mode type for the sequencer and the pattern each mode starts from.
// Ports:   none (package).
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  localparam int MAX_LEDS = 16;

  // Starting pattern for a mode, masked to n_leds bits. CHASE and BOUNCE
  // start one-hot at bit 0; BLINK and COUNT start dark.
  function automatic logic [MAX_LEDS-1:0] init_pattern(mode_t mode, int unsigned n_leds);
    logic [MAX_LEDS-1:0] mask;
    mask = (n_leds >= MAX_LEDS) ? '1 : ((MAX_LEDS'(1) << n_leds) - MAX_LEDS'(1));
    case (mode)
      MODE_CHASE, MODE_BOUNCE: init_pattern = MAX_LEDS'(1) & mask;
      default:                 init_pattern = '0;
    endcase
  endfunction

endpackage

// File: rtl/led_sequencer_btn_debounce.sv
// rtl/led_sequencer_btn_debounce.sv - push-button synchroniser and debouncer
//
// Purpose: turns a raw asynchronous button into a single-cycle press pulse.
// Ports:
//   CLK    in  system clock
//   RST_N  in  asynchronous active-low reset (accepted level returns to released)
//   raw    in  raw active-high button, asynchronous to CLK
//   press  out one-cycle pulse when a stable 0->1 level is accepted
module btn_debounce #(
  parameter int DEB_CYCLES = 120000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             accepted;
  logic [CNT_W-1:0] stable_cnt;

  // stable_cnt counts consecutive cycles where the synchronised level
  // disagrees with the accepted one; the DEB_CYCLES-th such cycle flips it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      accepted   <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == accepted) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        accepted   <= sync2;
        stable_cnt <= '0;
        press      <= sync2;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - parametrised LED pattern engine with button-selected mode
//
// Purpose: steps an N_LEDS-wide pattern at STEP_HZ in one of four modes; a
//          debounced button cycles the mode. Single clock, enables only.
// Ports:
//   CLK        in  system clock at CLK_HZ
//   RST_N      in  asynchronous active-low reset
//   BTN        in  raw active-high push-button
//   LEDS       out pattern, bit 0 = LED_RED0
//   HEARTBEAT  out toggles on every step tick
//   MODE       out current mode (0 CHASE, 1 BOUNCE, 2 BLINK, 3 COUNT)
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int STEP_HZ    = 10,
  parameter int N_LEDS     = 4,
  parameter int DEB_CYCLES = 120000,
  parameter int INIT_MODE  = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BTN,
  output logic [N_LEDS-1:0] LEDS,
  output logic              HEARTBEAT,
  output logic [1:0]        MODE
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam mode_t             INIT_M   = mode_t'(2'(INIT_MODE));
  localparam logic [N_LEDS-1:0] INIT_PAT = N_LEDS'(init_pattern(INIT_M, N_LEDS));
  localparam logic [N_LEDS-1:0] BIT0     = N_LEDS'(1);

  logic [DIV_W-1:0]  div_q;
  logic              tick;
  logic              hb_q;
  mode_t             mode_q, mode_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              dir_down_q, dir_down_d;
  logic              press;
  logic              one_hot;
  logic              go_down;
  logic [N_LEDS-1:0] shifted;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .CLK  (CLK),
    .RST_N(RST_N),
    .raw  (BTN),
    .press(press)
  );

  assign tick    = (div_q == DIV_LAST);
  assign one_hot = (leds_q != '0) && ((leds_q & (leds_q - BIT0)) == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q      <= '0;
      hb_q       <= 1'b0;
      mode_q     <= INIT_M;
      leds_q     <= INIT_PAT;
      dir_down_q <= 1'b0;
    end else begin
      div_q      <= tick ? '0 : div_q + DIV_W'(1);
      hb_q       <= hb_q ^ tick;
      mode_q     <= mode_d;
      leds_q     <= leds_d;
      dir_down_q <= dir_down_d;
    end
  end

  // A press takes priority over a coincident tick: the new mode's start
  // pattern is loaded and that tick's step is discarded.
  always_comb begin
    mode_d     = mode_q;
    leds_d     = leds_q;
    dir_down_d = dir_down_q;
    go_down    = 1'b0;
    shifted    = '0;
    if (press) begin
      mode_d     = mode_t'(mode_q + 2'd1);
      leds_d     = N_LEDS'(init_pattern(mode_d, N_LEDS));
      dir_down_d = 1'b0;
    end else if (tick) begin
      case (mode_q)
        MODE_CHASE: begin
          leds_d = one_hot ? ((leds_q << 1) | (leds_q >> (N_LEDS - 1))) : BIT0;
        end
        MODE_BOUNCE: begin
          if (!one_hot) begin
            leds_d     = BIT0;
            dir_down_d = 1'b0;
          end else if (N_LEDS > 1) begin
            // Turn at the ends so each end bit is lit for exactly one tick.
            go_down = leds_q[N_LEDS-1] || (dir_down_q && !leds_q[0]);
            shifted = go_down ? (leds_q >> 1) : (leds_q << 1);
            leds_d  = shifted;
            if (shifted[N_LEDS-1])  dir_down_d = 1'b1;
            else if (shifted[0])    dir_down_d = 1'b0;
            else                    dir_down_d = go_down;
          end
        end
        MODE_BLINK: leds_d = ~leds_q;
        MODE_COUNT: leds_d = leds_q + BIT0;
        default:    leds_d = leds_q;
      endcase
    end
  end

  assign LEDS      = leds_q;
  assign HEARTBEAT = hb_q;
  assign MODE      = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - self-checking bench for led_sequencer, all four INIT_MODEs
module tb_led_sequencer;

  localparam int TICK_DIV = 10;
  localparam int DEB      = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn   = 1'b0;
  logic [3:0] leds [4];
  logic       hb   [4];
  logic [1:0] mode [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    led_sequencer #(
      .CLK_HZ    (100),
      .STEP_HZ   (10),
      .N_LEDS    (4),
      .DEB_CYCLES(DEB),
      .INIT_MODE (g)
    ) u_dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .BTN      (btn),
      .LEDS     (leds[g]),
      .HEARTBEAT(hb[g]),
      .MODE     (mode[g])
    );
  end

  // Reference model: mode plus number of steps taken since the mode was
  // entered; the pattern is a closed-form function of those two numbers.
  int m_edges;
  int m_mode [4];
  int m_step [4];
  bit m_hb;
  bit m_acc;
  bit m_press_pend;
  bit btn_hist[$];
  bit win[$];

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pat(input int md, input int k);
    int ph;
    case (md)
      0: pat = 1 << (k % 4);
      1: begin
        ph  = k % 6;
        pat = 1 << ((ph < 4) ? ph : 6 - ph);
      end
      2: pat = (k % 2 == 1) ? 15 : 0;
      default: pat = k % 16;
    endcase
  endfunction

  task automatic model_reset();
    m_edges = 0;
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = i;
      m_step[i] = 0;
    end
    m_hb         = 1'b0;
    m_acc        = 1'b0;
    m_press_pend = 1'b0;
    btn_hist.delete();
    win.delete();
  endtask

  task automatic model_edge();
    bit s;
    bit tick;
    bit all_new;
    if (!rst_n) return;
    m_edges++;
    // Debouncer sees the button two edges late through the synchroniser.
    btn_hist.push_back(btn);
    if (btn_hist.size() > 3) void'(btn_hist.pop_front());
    s    = (btn_hist.size() == 3) ? btn_hist[0] : 1'b0;
    tick = (m_edges % TICK_DIV == 0);
    for (int i = 0; i < 4; i++) begin
      if (m_press_pend) begin
        m_mode[i] = (m_mode[i] + 1) % 4;
        m_step[i] = 0;
      end else if (tick) begin
        m_step[i]++;
      end
    end
    if (tick) m_hb = !m_hb;
    win.push_back(s);
    if (win.size() > DEB) void'(win.pop_front());
    all_new = (win.size() == DEB);
    foreach (win[j]) if (win[j] == m_acc) all_new = 1'b0;
    m_press_pend = 1'b0;
    if (all_new) begin
      m_acc        = !m_acc;
      m_press_pend = m_acc;
    end
  endtask

  task automatic check_all(input string phase);
    int exp;
    for (int i = 0; i < 4; i++) begin
      exp = m_mode[i] * 32 + int'(m_hb) * 16 + pat(m_mode[i], m_step[i]);
      check($sformatf("%s dut%0d t=%0t", phase, i, $time),
            int'({mode[i], hb[i], leds[i]}), exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all("run");
  endtask

  task automatic run(input int c);
    repeat (c) cycle();
  endtask

  // Called at a falling clock edge; reset is asserted mid-cycle, held
  // across one rising edge and released at the next falling edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all("por");
    check("por_leds0", int'(leds[0]), 1);
    check("por_leds2", int'(leds[2]), 0);
    check("por_mode3", int'(mode[3]), 3);
    check("por_hb0", int'(hb[0]), 0);
    rst_n = 1'b1;

    // CHASE timing from reset release.
    run(9);
    check("chase_c9", int'(leds[0]), 1);
    run(1);
    check("chase_c10", int'(leds[0]), 2);
    check("hb_c10", int'(hb[0]), 1);
    check("blink_c10", int'(leds[2]), 15);
    run(35);
    check("chase_c45", int'(leds[0]), 1);

    // BOUNCE for 7 ticks, COUNT wrap after 16 ticks.
    pulse_reset();
    run(70);
    check("bounce_7t", int'(leds[1]), 2);
    check("count_7t", int'(leds[3]), 7);
    run(90);
    check("count_wrap", int'(leds[3]), 0);
    check("blink_16t", int'(leds[2]), 0);

    // Bounces shorter than the debounce window.
    btn = 1'b1; run(2);
    btn = 1'b0; run(2);
    btn = 1'b1; run(3);
    btn = 1'b0; run(12);
    check("bounce_nopress", int'(mode[0]), 0);

    // Clean press: MODE changes on the 7th edge after BTN rises.
    pulse_reset();
    btn = 1'b1;
    run(6);
    check("press_lat6", int'(mode[0]), 0);
    run(1);
    check("press_lat7", int'(mode[0]), 1);
    check("press_leds", int'(leds[0]), 1);
    run(13);
    btn = 1'b0;
    run(10);
    check("press_once", int'(mode[0]), 1);

    // Press coincides with the tick at edge 30 while CHASE shows 0100.
    pulse_reset();
    run(23);
    btn = 1'b1;
    run(7);
    check("coinc_mode", int'(mode[0]), 1);
    check("coinc_leds", int'(leds[0]), 1);
    check("coinc_hb", int'(hb[0]), 1);
    for (int p = 0; p < 3; p++) begin
      btn = 1'b0; run(10);
      btn = 1'b1; run(10);
    end
    btn = 1'b0; run(10);
    check("four_press", int'(mode[0]), 0);

    // Reset mid-BOUNCE and mid-debounce with the button held.
    run(20);
    btn = 1'b1;
    run(2);
    pulse_reset();
    check("rst_mode0", int'(mode[0]), 0);
    check("rst_leds1", int'(leds[1]), 1);
    run(6);
    check("held_lat6", int'(mode[0]), 0);
    run(1);
    check("held_lat7", int'(mode[0]), 1);
    run(30);
    check("held_stays", int'(mode[0]), 1);
    btn = 1'b0;
    run(10);

    // Random button activity with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      btn = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 12)));
      if ($urandom_range(0, 39) == 0) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
